// File: rtl/add16_share_ctrl.sv
// Round-robin share controller for one pipelined 16-bit adder: grants a requester, holds its
// operands for the adder pipeline and returns the 17-bit result. Optional grant lock: ADDSHARE_LOCK_EN.
module add16_share_ctrl #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned LAT  = 3,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*16-1:0]   req_a,
    input  logic [NREQ*16-1:0]   req_b,
    input  logic [NREQ-1:0]      req_cin,
    input  logic [NREQ-1:0]      req_lock,
    output logic [15:0]          add_a,
    output logic [15:0]          add_b,
    output logic [1:0]           add_kin,
    input  logic [16:0]          add_sum,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [16:0]          rsp_sum
);

    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {StIdle, StHold, StResp} state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     b_q, b_d;
    logic [1:0]      kin_q, kin_d;
    logic [NREQ-1:0] rv_q, rv_d;
    logic [IDW-1:0]  rid_q, rid_d;
    logic [16:0]     rsum_q, rsum_d;

    logic            any;
    logic [IDW-1:0]  gnt;
    logic [IDW-1:0]  sel;
    logic [IDW-1:0]  nxt_ptr;
    int              idx;

`ifdef ADDSHARE_LOCK_EN
    logic lock_q, lock_d;
    logic locked;
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // Winner search starts at ptr and wraps; a pending lock overrides it.
    always_comb begin
        any = 1'b0;
        gnt = '0;
        sel = '0;
        idx = 0;
        for (int off = 0; off < int'(NREQ); off++) begin
            idx = (int'(ptr_q) + off) % int'(NREQ);
            sel = IDW'(idx);
            if (!any && req_valid[sel]) begin
                any = 1'b1;
                gnt = sel;
            end
        end
`ifdef ADDSHARE_LOCK_EN
        locked = 1'b0;
        if (lock_q && req_valid[id_q]) begin
            any    = 1'b1;
            gnt    = id_q;
            locked = 1'b1;
        end
`endif
    end

    assign nxt_ptr = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        kin_d     = kin_q;
        rv_d      = '0;
        rid_d     = rid_q;
        rsum_d    = rsum_q;
        req_ready = '0;
`ifdef ADDSHARE_LOCK_EN
        lock_d    = lock_q;
`endif
        unique case (state_q)
            StIdle: begin
`ifdef ADDSHARE_LOCK_EN
                lock_d = 1'b0;
`endif
                if (any && rst_n) begin
                    req_ready[gnt] = 1'b1;
                    a_d     = req_a[int'(gnt)*16 +: 16];
                    b_d     = req_b[int'(gnt)*16 +: 16];
                    kin_d   = req_cin[gnt] ? 2'b11 : 2'b00;
                    id_d    = gnt;
                    ptr_d   = nxt_ptr;
`ifdef ADDSHARE_LOCK_EN
                    if (locked) ptr_d = ptr_q;
`endif
                    cnt_d   = CW'(LAT - 1);
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    rsum_d     = add_sum;
                    rid_d      = id_q;
                    rv_d[id_q] = 1'b1;
                    state_d    = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
`ifdef ADDSHARE_LOCK_EN
                lock_d = req_lock[id_q];
`endif
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            kin_q   <= 2'b00;
            rv_q    <= '0;
            rid_q   <= '0;
            rsum_q  <= '0;
`ifdef ADDSHARE_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            kin_q   <= kin_d;
            rv_q    <= rv_d;
            rid_q   <= rid_d;
            rsum_q  <= rsum_d;
`ifdef ADDSHARE_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_kin   = kin_q;
    assign rsp_valid = rv_q;
    assign rsp_id    = rid_q;
    assign rsp_sum   = rsum_q;

endmodule
